// File: rtl/byte_word_packer.sv
// Packs an accepted byte stream MSB-first into 32-bit words and queues them in a
// first-word-fall-through FIFO drained over a valid/ready interface.
module byte_word_packer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PAD_BYTE   = 8'h00
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    data_in,
    input  logic                          data_en,
    input  logic                          flush,
    output logic [31:0]                   word_o,
    output logic [2:0]                    word_bytes,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [1:0]    byte_cnt_r;
    logic [23:0]   acc_r;
    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [2:0]    bytes_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic          accept_s;
    logic [31:0]   accw_s;
    logic [31:0]   merged_s;
    logic [2:0]    push_bytes_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          wr_en_s;
    logic          drop_s;

    assign accept_s     = start && data_en;
    assign accw_s       = {acc_r, PAD_BYTE};
    assign push_bytes_s = {1'b0, byte_cnt_r} + {2'b00, accept_s};
    assign push_s       = (accept_s && (byte_cnt_r == 2'd3)) ||
                          (flush && ((byte_cnt_r != 2'd0) || accept_s));

    assign word_valid = (count_r != {CW{1'b0}});
    assign pop_s      = word_valid && word_ready;
    assign full_s     = (count_r == FULL_CNT);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign wr_en_s    = push_s && (!full_s || pop_s);
    assign drop_s     = push_s && full_s && !pop_s;

    assign word_o     = word_valid ? mem_r[rd_ptr_r] : 32'h0000_0000;
    assign word_bytes = word_valid ? bytes_mem_r[rd_ptr_r] : 3'd0;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

    // Lane merge: held bytes, then this cycle's byte, then padding.
    always_comb begin
        merged_s = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(byte_cnt_r)) begin
                merged_s[31-8*i -: 8] = accw_s[31-8*i -: 8];
            end else if (accept_s && (i == int'(byte_cnt_r))) begin
                merged_s[31-8*i -: 8] = data_in;
            end else begin
                merged_s[31-8*i -: 8] = PAD_BYTE;
            end
        end
    end

    // Byte assembler: counter and partial-word accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_r <= 2'd0;
            acc_r      <= 24'h00_0000;
        end else if (push_s) begin
            byte_cnt_r <= 2'd0;
            acc_r      <= 24'h00_0000;
        end else if (accept_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            acc_r      <= merged_s[31:8];
        end else begin
            byte_cnt_r <= byte_cnt_r;
            acc_r      <= acc_r;
        end
    end

    // FIFO storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r]       <= merged_s;
            bytes_mem_r[wr_ptr_r] <= push_bytes_s;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

endmodule
